// File: rtl/pixcomp_pipe.sv
// Pipelined pattern/data comparator for the blitter: per-lane compare, pixel merge,
// two-stage elastic valid/ready pipeline and a saturating hit counter.
module pixcomp_pipe #(
  parameter int unsigned LANES  = 8,
  parameter int unsigned LANE_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    resetl,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    cmpdst,
  input  logic [1:0]              pixsize,
  input  logic                    invert,
  input  logic                    pat_ld,
  input  logic [LANES*LANE_W-1:0] patd,
  input  logic [LANES*LANE_W-1:0] srcd,
  input  logic [LANES*LANE_W-1:0] dstd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        dcomp,
  output logic                    any_hit,
  input  logic                    cnt_clr,
  output logic [CNT_W-1:0]        hit_cnt
);

  localparam int unsigned DW = LANES * LANE_W;

  logic [DW-1:0]    pat_q;
  logic             s1_valid;
  logic [LANES-1:0] s1_eq;
  logic [1:0]       s1_pixsize;
  logic             s1_invert;

  logic             s2_ready;
  logic             s1_move;
  logic             accept;
  logic             hit_xfer;
  logic [DW-1:0]    tar_c;
  logic [LANES-1:0] lane_eq_c;
  logic [LANES-1:0] pix_eq_c;
  logic [LANES-1:0] dcomp_c;

  // Elastic handshake: each stage advances when its successor empties or transfers
  assign s2_ready = !out_valid || out_ready;
  assign s1_move  = s1_valid && s2_ready;
  assign in_ready = !s1_valid || s1_move;
  assign accept   = in_valid && in_ready;
  assign hit_xfer = out_valid && out_ready && any_hit;

  // Stage 1 compare: target selection and per-lane equality against the held pattern
  always_comb begin
    tar_c     = cmpdst ? dstd : srcd;
    lane_eq_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_eq_c[i] = (pat_q[i*LANE_W +: LANE_W] == tar_c[i*LANE_W +: LANE_W]);
    end
  end

  // Stage 2 merge: a lane's pixel is every lane sharing its index >> pixsize
  always_comb begin
    pix_eq_c = '1;
    for (int unsigned i = 0; i < LANES; i++) begin
      for (int unsigned j = 0; j < LANES; j++) begin
        if ((j >> s1_pixsize) == (i >> s1_pixsize)) begin
          pix_eq_c[i] = pix_eq_c[i] & s1_eq[j];
        end
      end
    end
    dcomp_c = pix_eq_c ^ {LANES{s1_invert}};
  end

  // Pattern register; a beat accepted alongside pat_ld still sees the old value
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      pat_q <= '0;
    end else if (pat_ld) begin
      pat_q <= patd;
    end
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      s1_valid   <= 1'b0;
      s1_eq      <= '0;
      s1_pixsize <= 2'd0;
      s1_invert  <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_eq      <= lane_eq_c;
        s1_pixsize <= pixsize;
        s1_invert  <= invert;
      end
    end
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      out_valid <= 1'b0;
      dcomp     <= '0;
      any_hit   <= 1'b0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        dcomp   <= dcomp_c;
        any_hit <= |dcomp_c;
      end
    end
  end

  // Saturating hit counter; clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      hit_cnt <= '0;
    end else if (cnt_clr) begin
      hit_cnt <= '0;
    end else if (hit_xfer && (hit_cnt != {CNT_W{1'b1}})) begin
      hit_cnt <= hit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pixcomp_pipe.sv
// Directed self-checking bench for pixcomp_pipe with hand-computed expectations.
module tb_pixcomp_pipe;

  localparam int unsigned LANES  = 8;
  localparam int unsigned LANE_W = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DW     = LANES * LANE_W;

  localparam logic [DW-1:0] PAT = 64'h1122_3344_5566_7788;
  localparam logic [DW-1:0] NEW = 64'h0102_0304_0506_0708;

  logic             clk;
  logic             resetl;
  logic             in_valid;
  logic             in_ready;
  logic             cmpdst;
  logic [1:0]       pixsize;
  logic             invert;
  logic             pat_ld;
  logic [DW-1:0]    patd;
  logic [DW-1:0]    srcd;
  logic [DW-1:0]    dstd;
  logic             out_valid;
  logic             out_ready;
  logic [LANES-1:0] dcomp;
  logic             any_hit;
  logic             cnt_clr;
  logic [CNT_W-1:0] hit_cnt;

  int n_checks;
  int n_fail;

  pixcomp_pipe #(.LANES(LANES), .LANE_W(LANE_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .resetl    (resetl),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cmpdst    (cmpdst),
    .pixsize   (pixsize),
    .invert    (invert),
    .pat_ld    (pat_ld),
    .patd      (patd),
    .srcd      (srcd),
    .dstd      (dstd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dcomp     (dcomp),
    .any_hit   (any_hit),
    .cnt_clr   (cnt_clr),
    .hit_cnt   (hit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic cd, input logic [1:0] ps, input logic inv,
                       input logic [DW-1:0] s, input logic [DW-1:0] d);
    in_valid = v;
    cmpdst   = cd;
    pixsize  = ps;
    invert   = inv;
    srcd     = s;
    dstd     = d;
  endtask

  // One isolated beat with out_ready high: accept, then result visible one edge later
  task automatic one_beat(input string tag, input logic cd, input logic [1:0] ps, input logic inv,
                          input logic [DW-1:0] s, input logic [DW-1:0] d,
                          input logic [7:0] exp_dc);
    drive(1'b1, cd, ps, inv, s, d);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    tick();
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(1));
    chk({tag, "_dcomp"}, 64'(dcomp), 64'(exp_dc));
    chk({tag, "_any_hit"}, 64'(any_hit), 64'(|exp_dc));
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    resetl    = 1'b0;
    out_ready = 1'b1;
    pat_ld    = 1'b0;
    patd      = '0;
    cnt_clr   = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 1'b0, '0, '0);

    tick();
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_dcomp", 64'(dcomp), 64'(0));
    chk("rst_any_hit", 64'(any_hit), 64'(0));
    chk("rst_hit_cnt", 64'(hit_cnt), 64'(0));
    resetl = 1'b1;
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    // Test 1: exact match
    pat_ld = 1'b1;
    patd   = PAT;
    tick();
    pat_ld = 1'b0;
    one_beat("t1", 1'b0, 2'd0, 1'b0, PAT, '0, 8'hFF);
    chk("t1_cnt_before", 64'(hit_cnt), 64'(0));
    tick();
    chk("t1_hit_cnt", 64'(hit_cnt), 64'(1));
    chk("t1_drained", 64'(out_valid), 64'(0));

    // Test 2: pixel merge and inversion
    one_beat("t2_ps1", 1'b0, 2'd1, 1'b0, 64'h1122_3344_5566_7700, '0, 8'hFC);
    one_beat("t2_ps3", 1'b0, 2'd3, 1'b0, 64'h1122_3344_5566_7700, '0, 8'h00);
    one_beat("t2_inv", 1'b0, 2'd3, 1'b1, 64'h1122_3344_5566_7700, '0, 8'hFF);
    tick();
    chk("t2_hit_cnt", 64'(hit_cnt), 64'(3));

    // Test 3: target select, back-to-back beats
    drive(1'b1, 1'b1, 2'd0, 1'b0, '0, PAT);
    tick();
    drive(1'b1, 1'b0, 2'd0, 1'b0, '0, PAT);
    chk("t3_in_ready_b2b", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    chk("t3_dst_valid", 64'(out_valid), 64'(1));
    chk("t3_dst_dcomp", 64'(dcomp), 64'(8'hFF));
    tick();
    chk("t3_src_valid", 64'(out_valid), 64'(1));
    chk("t3_src_dcomp", 64'(dcomp), 64'(8'h00));
    tick();
    chk("t3_hit_cnt", 64'(hit_cnt), 64'(4));

    // Test 4: stall with two buffered beats
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 2'd0, 1'b0, PAT, '0);
    chk("t4_rdy1", 64'(in_ready), 64'(1));
    tick();
    drive(1'b1, 1'b0, 2'd0, 1'b0, 64'h1122_3344_5566_7700, '0);
    chk("t4_rdy2", 64'(in_ready), 64'(1));
    tick();
    drive(1'b1, 1'b0, 2'd0, 1'b0, 64'h0022_3344_5566_7788, '0);
    chk("t4_rdy3_blocked", 64'(in_ready), 64'(0));
    tick();
    chk("t4_still_blocked", 64'(in_ready), 64'(0));
    chk("t4_stall_valid", 64'(out_valid), 64'(1));
    chk("t4_stall_dcomp_a", 64'(dcomp), 64'(8'hFF));
    tick();
    chk("t4_stall_dcomp_b", 64'(dcomp), 64'(8'hFF));
    chk("t4_stall_cnt", 64'(hit_cnt), 64'(4));
    out_ready = 1'b1;
    #1;
    chk("t4_rdy_release", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    chk("t4_res2", 64'(dcomp), 64'(8'hFE));
    tick();
    chk("t4_res3", 64'(dcomp), 64'(8'h7F));
    tick();
    chk("t4_drained", 64'(out_valid), 64'(0));
    chk("t4_hit_cnt", 64'(hit_cnt), 64'(7));

    // Test 5: beat accepted with pat_ld compares against the old pattern
    pat_ld = 1'b1;
    patd   = '0;
    tick();
    patd = NEW;
    drive(1'b1, 1'b0, 2'd0, 1'b0, NEW, '0);
    tick();
    pat_ld = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("t5_old_pat", 64'(dcomp), 64'(8'h00));
    tick();
    chk("t5_new_pat", 64'(dcomp), 64'(8'hFF));
    tick();
    chk("t5_hit_cnt", 64'(hit_cnt), 64'(8));

    // Test 6: saturation, clear priority, reset mid-stall
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("t6_clr", 64'(hit_cnt), 64'(0));
    drive(1'b1, 1'b0, 2'd0, 1'b0, NEW, '0);
    for (int k = 0; k < 65534; k++) tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("t6_preload", 64'(hit_cnt), 64'(16'hFFFE));
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("t6_saturate", 64'(hit_cnt), 64'(16'hFFFF));
    tick();
    chk("t6_sat_hold", 64'(hit_cnt), 64'(16'hFFFF));
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    cnt_clr = 1'b1;
    chk("t6_clr_pending_hit", 64'(any_hit & out_valid), 64'(1));
    tick();
    cnt_clr = 1'b0;
    chk("t6_clr_priority", 64'(hit_cnt), 64'(0));

    out_ready = 1'b0;
    in_valid  = 1'b1;
    tick();
    tick();
    tick();
    in_valid = 1'b0;
    chk("t6_stall_full", 64'(in_ready), 64'(0));
    chk("t6_stall_valid", 64'(out_valid), 64'(1));
    resetl = 1'b0;
    #1;
    chk("t6_async_valid", 64'(out_valid), 64'(0));
    chk("t6_async_dcomp", 64'(dcomp), 64'(0));
    tick();
    resetl    = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("t6_no_stale_a", 64'(out_valid), 64'(0));
    tick();
    chk("t6_no_stale_b", 64'(out_valid), 64'(0));
    chk("t6_post_rst_rdy", 64'(in_ready), 64'(1));
    one_beat("t6_pat_cleared", 1'b0, 2'd0, 1'b0, '0, '0, 8'hFF);
    tick();
    chk("t6_post_rst_cnt", 64'(hit_cnt), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
